// File: rtl/psmux_pkg.sv
// Shared types and helpers for the pipelined parity-select mux.
// psmux_state_t encodes skid-buffer occupancy; parity_sel() picks the operand side.
package psmux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } psmux_state_t;

  localparam int unsigned MAX_SEL_W = 32;

  // Returns 1 when data_b is selected. odd_sel_b=1 maps odd parity to B.
  function automatic logic parity_sel(input logic [MAX_SEL_W-1:0] sel,
                                      input logic                 odd_sel_b);
    return (^sel) ~^ odd_sel_b;
  endfunction

endpackage

// File: rtl/psmux_skid_buf.sv
// Two-entry valid/ready skid buffer: main register drives the outputs, the skid
// register absorbs one beat while downstream stalls. in_ready is fully registered.
module psmux_skid_buf
  import psmux_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  psmux_state_t state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, drain;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid && out_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Looking at the next state keeps out_ready off any combinational path to in_ready.
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      // NOTE: both payload registers are reset; main_q drives data_out, which must read 0.
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/parity_sel_mux_pipe.sv
// Registered parity-select mux: ^sel picks data_a or data_b, output via skid buffer.
// Define PSMUX_CNT_EN to add saturating even/odd accept counters (cnt_even, cnt_odd).
module parity_sel_mux_pipe
  import psmux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_W     = 4,
`ifdef PSMUX_CNT_EN
  parameter int ODD_SEL_B = 1,
  parameter int CNT_W     = 16
`else
  parameter int ODD_SEL_B = 1
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
`ifdef PSMUX_CNT_EN
  output logic             out_par,
  output logic [CNT_W-1:0] cnt_even,
  output logic [CNT_W-1:0] cnt_odd
`else
  output logic             out_par
`endif
);

  logic             par;
  logic             take_b;
  logic [WIDTH:0]   in_payload;
  logic [WIDTH:0]   out_payload;

  assign par        = ^sel;
  assign take_b     = parity_sel(MAX_SEL_W'(sel), (ODD_SEL_B != 0));
  assign in_payload = {par, (take_b ? data_b : data_a)};

  psmux_skid_buf #(.W(WIDTH + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign data_out = out_payload[WIDTH-1:0];
  assign out_par  = out_payload[WIDTH];

`ifdef PSMUX_CNT_EN
  logic accept;
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_even <= '0;
      cnt_odd  <= '0;
    end else if (accept) begin
      // Saturate at all-ones rather than wrapping.
      if (par) begin
        if (cnt_odd != '1) cnt_odd <= cnt_odd + CNT_W'(1);
      end else begin
        if (cnt_even != '1) cnt_even <= cnt_even + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_parity_sel_mux_pipe.sv
// Self-checking bench for parity_sel_mux_pipe: constant vector table, stall/reset
// sequences and random traffic against a queue-based reference model.
module tb_parity_sel_mux_pipe;

  localparam int WIDTH = 8;
  localparam int SEL_W = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SEL_W-1:0] sel = '0;
  logic [WIDTH-1:0] data_a = '0;
  logic [WIDTH-1:0] data_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             out_par;
`ifdef PSMUX_CNT_EN
  logic [CNT_W-1:0] cnt_even;
  logic [CNT_W-1:0] cnt_odd;
`endif

`ifdef PSMUX_CNT_EN
  parity_sel_mux_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W), .ODD_SEL_B(1), .CNT_W(CNT_W)) dut (
`else
  parity_sel_mux_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W), .ODD_SEL_B(1)) dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .data_a    (data_a),
    .data_b    (data_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
`ifdef PSMUX_CNT_EN
    .out_par   (out_par),
    .cnt_even  (cnt_even),
    .cnt_odd   (cnt_odd)
`else
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO of {parity, data} beats the block currently holds.
  logic [WIDTH:0] q[$];
  bit             ready_m = 1'b0;
  int             n_acc = 0;
  int             cnt_e_m = 0;
  int             cnt_o_m = 0;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_data;
    logic             exp_par;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Odd number of ones in sel -> data_b, otherwise data_a.
  function automatic logic [WIDTH:0] ref_beat(input logic [SEL_W-1:0] s,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic odd;
    odd = (($countones(s) % 2) == 1);
    return {odd, (odd ? b : a)};
  endfunction

  task automatic compare_state();
    check("in_ready", in_ready, ready_m);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("data_out", data_out, q[0][WIDTH-1:0]);
      check("out_par", out_par, q[0][WIDTH]);
    end
`ifdef PSMUX_CNT_EN
    check("cnt_even", cnt_even, cnt_e_m);
    check("cnt_odd", cnt_odd, cnt_o_m);
`endif
  endtask

  // One clock: predict transfers from model state, advance, then compare at edge+1.
  task automatic step();
    bit             acc;
    bit             drn;
    logic [WIDTH:0] beat;
    acc  = rst_n && in_valid && ready_m;
    drn  = rst_n && (q.size() > 0) && out_ready;
    beat = ref_beat(sel, data_a, data_b);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      ready_m = 1'b0;
      cnt_e_m = 0;
      cnt_o_m = 0;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(beat);
        n_acc++;
        if (beat[WIDTH]) cnt_o_m = (cnt_o_m < CNT_MAX) ? cnt_o_m + 1 : CNT_MAX;
        else             cnt_e_m = (cnt_e_m < CNT_MAX) ? cnt_e_m + 1 : CNT_MAX;
      end
      ready_m = (q.size() < 2);
    end
    #1;
    compare_state();
  endtask

  task automatic drive(input bit v, input logic [SEL_W-1:0] s,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = v;
    sel      = s;
    data_a   = a;
    data_b   = b;
  endtask

  // Asynchronous reset asserted and released away from clock edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    ready_m = 1'b0;
    cnt_e_m = 0;
    cnt_o_m = 0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst_out_par", out_par, 1'b0);
    step();
    step();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t vecs[6];
    int   acc0;
    int   ready_drops;

    vecs[0] = '{sel: 4'b0010, a: 8'h55, b: 8'hAA, exp_data: 8'hAA, exp_par: 1'b1};
    vecs[1] = '{sel: 4'b0011, a: 8'h55, b: 8'hAA, exp_data: 8'h55, exp_par: 1'b0};
    vecs[2] = '{sel: 4'b0000, a: 8'h12, b: 8'h34, exp_data: 8'h12, exp_par: 1'b0};
    vecs[3] = '{sel: 4'b1111, a: 8'hF0, b: 8'h0F, exp_data: 8'hF0, exp_par: 1'b0};
    vecs[4] = '{sel: 4'b0111, a: 8'h00, b: 8'hFF, exp_data: 8'hFF, exp_par: 1'b1};
    vecs[5] = '{sel: 4'b1000, a: 8'hC3, b: 8'h3C, exp_data: 8'h3C, exp_par: 1'b1};

    // Reset state, then in_ready must rise on the first edge after release.
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_data_out", data_out, '0);
    #12;
    rst_n = 1'b1;
    step();
    check("ready_after_reset", in_ready, 1'b1);

    // Vector table: one beat at a time, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].sel, vecs[i].a, vecs[i].b);
      step();
      check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
      check($sformatf("vec%0d_par", i), out_par, vecs[i].exp_par);
      drive(1'b0, '0, '0, '0);
      step();
    end

    // Stall: three beats offered with out_ready low, only two taken.
    out_ready = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, SEL_W'(i), WIDTH'(8'h10 + i), WIDTH'(8'h20 + i));
      step();
    end
    check("stall_accepted", n_acc - acc0, 2);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_hold_data", data_out, 8'h10);
    step();
    check("stall_hold_again", data_out, 8'h10);
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("stall_drained", out_valid, 1'b0);

    // Streaming: one beat per cycle, in_ready never drops.
    acc0 = n_acc;
    ready_drops = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, SEL_W'($urandom), WIDTH'($urandom), WIDTH'($urandom));
      step();
      if (!in_ready) ready_drops++;
    end
    check("stream_accepted", n_acc - acc0, 20);
    check("stream_ready_drops", ready_drops, 0);
    drive(1'b0, '0, '0, '0);
    step();

    // Reset while holding two beats drops both; next accepted beat is first out.
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 8'hA1, 8'hB1);
    step();
    drive(1'b1, 4'b0000, 8'hA2, 8'hB2);
    step();
    check("two_full", in_ready, 1'b0);
    drive(1'b0, '0, '0, '0);
    do_reset();
    drive(1'b1, 4'b0101, 8'h77, 8'h88);
    step();
    check("post_rst_not_taken", out_valid, 1'b0);
    step();
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    check("post_rst_first", data_out, 8'h77);
    step();

`ifdef PSMUX_CNT_EN
    // Counter saturation: five odd beats on a 2-bit counter.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0001, WIDTH'(i), WIDTH'(8'h40 + i));
      step();
    end
    drive(1'b0, '0, '0, '0);
    step();
    check("cnt_odd_sat", cnt_odd, 2'd3);
    check("cnt_even_zero", cnt_even, 2'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), SEL_W'($urandom), WIDTH'($urandom), WIDTH'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("final_empty", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
